// File: rtl/count_sat_monitor_if.sv
// Bus between the sn/i counter stage, the result sink and count_sat_monitor.
// The monitor connects through the master modport; the counter/sink side uses slave.
//
// Handshake: res_valid rises only together with a complete record
// (res_sn/res_stalls/res_err). The record stays constant and res_valid stays
// high until a posedge at which res_valid && res_ready. That edge is the single
// transfer. res_ready may be high before res_valid, but that does not make the
// transfer happen any earlier.
interface count_sat_monitor_if #(
    parameter int WIDTH   = 8,
    parameter int STALL_W = 16
);
    logic [WIDTH-1:0]   sn_in;
    logic [WIDTH-1:0]   i_in;
    logic               res_ready;
    logic               res_valid;
    logic [WIDTH-1:0]   res_sn;
    logic [STALL_W-1:0] res_stalls;
    logic               res_err;
    logic               err_live;
    logic               busy;
    logic [1:0]         state_dbg;   // FSM state: 0 IDLE, 1 TRACK, 2 REPORT, 3 HALT

    modport master (
        input  sn_in, i_in, res_ready,
        output res_valid, res_sn, res_stalls, res_err, err_live, busy, state_dbg
    );

    modport slave (
        output sn_in, i_in, res_ready,
        input  res_valid, res_sn, res_stalls, res_err, err_live, busy, state_dbg
    );
endinterface

// File: rtl/count_sat_monitor.sv
// Monitor for the gated saturating sn/i counter. It follows each run from
// (i=1, sn=0) to i=LIMIT+1. On every cycle it checks that the pair is
// consistent and counts the cycles in which i does not advance. When the run
// ends it sends one result record over a valid/ready handshake.
module count_sat_monitor #(
    parameter int WIDTH   = 8,
    parameter int LIMIT   = 200,
    parameter int STALL_W = 16
) (
    input logic clk,
    input logic rst,
    count_sat_monitor_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        REPORT = 2'd2,
        HALT   = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0]   ONE    = WIDTH'(1);
    // LIMIT+1 must fit in WIDTH bits. If it does not, the terminal value wraps.
    localparam logic [WIDTH-1:0]   TERM_I = WIDTH'(LIMIT + 1);
    localparam logic [STALL_W-1:0] S_ONE  = STALL_W'(1);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   prev_i, prev_sn;
    logic [WIDTH-1:0]   di, ds;
    logic [STALL_W-1:0] stalls, stalls_nxt;
    logic               err_q;
    logic               res_valid_q, res_err_q;
    logic [WIDTH-1:0]   res_sn_q;
    logic [STALL_W-1:0] res_stalls_q;
    logic               start_c, term_c, stall_now, viol, arm;

    // Per-cycle comparison of the sampled pair against the previous sample (mod 2^WIDTH)
    always_comb begin
        di         = bus.i_in - prev_i;
        ds         = bus.sn_in - prev_sn;
        start_c    = (bus.i_in == ONE) && (bus.sn_in == '0);
        term_c     = (bus.i_in == TERM_I);
        stall_now  = (di == '0);
        viol       = ((di != '0) && (di != ONE)) ||
                     (ds != di) ||
                     (bus.sn_in != (bus.i_in - ONE)) ||
                     (bus.i_in > TERM_I);
        stalls_nxt = (stall_now && (stalls != '1)) ? (stalls + S_ONE) : stalls;
    end

    // Next-state logic. arm marks the cycles in which a new run starts tracking
    always_comb begin
        state_nxt = state;
        arm       = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (start_c) begin
                    state_nxt = TRACK;
                    arm       = 1'b1;
                end
            end
            TRACK: begin
                if (term_c) state_nxt = REPORT;
            end
            REPORT: begin
                if (res_valid_q && bus.res_ready) begin
                    arm       = start_c;
                    state_nxt = start_c ? TRACK : HALT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Run tracking, stall count, sticky error and the result record
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_i       <= '0;
            prev_sn      <= '0;
            stalls       <= '0;
            err_q        <= 1'b0;
            res_valid_q  <= 1'b0;
            res_sn_q     <= '0;
            res_stalls_q <= '0;
            res_err_q    <= 1'b0;
        end else begin
            if (arm) begin
                prev_i  <= bus.i_in;
                prev_sn <= bus.sn_in;
                stalls  <= '0;
                err_q   <= 1'b0;
            end else if (state == TRACK) begin
                prev_i  <= bus.i_in;
                prev_sn <= bus.sn_in;
                stalls  <= stalls_nxt;
                if (viol) err_q <= 1'b1;
            end
            if ((state == TRACK) && term_c) begin
                res_valid_q  <= 1'b1;
                res_sn_q     <= bus.sn_in;
                res_stalls_q <= stalls_nxt;
                res_err_q    <= err_q | viol;
            end else if ((state == REPORT) && bus.res_ready) begin
                res_valid_q  <= 1'b0;
            end
        end
    end

    // Output drive
    always_comb begin
        bus.res_valid  = res_valid_q;
        bus.res_sn     = res_sn_q;
        bus.res_stalls = res_stalls_q;
        bus.res_err    = res_err_q;
        bus.err_live   = err_q;
        bus.busy       = (state == TRACK) || (state == REPORT);
        bus.state_dbg  = state;
    end
endmodule

// File: tb/tb_count_sat_monitor.sv
// Testbench for count_sat_monitor. Two instances get the same stimulus: one
// with a 16-bit stall counter and one with a 4-bit stall counter, to exercise
// saturation. The bench plays the counter stage itself. Every cycle it decides
// how many stall cycles to hold each i value and whether to corrupt sn, so the
// expected record of every run comes from that scenario.
module tb_count_sat_monitor;
    localparam int WIDTH = 8;
    localparam int LIMIT = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    count_sat_monitor_if #(.WIDTH(WIDTH), .STALL_W(16)) u_if ();
    count_sat_monitor_if #(.WIDTH(WIDTH), .STALL_W(4))  u_if4 ();

    count_sat_monitor #(.WIDTH(WIDTH), .LIMIT(LIMIT), .STALL_W(16)) u_dut (
        .clk(clk), .rst(rst), .bus(u_if.master)
    );
    count_sat_monitor #(.WIDTH(WIDTH), .LIMIT(LIMIT), .STALL_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .bus(u_if4.master)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int n_xfer = 0;
    logic [24:0] exp_q[$];   // {err, stalls[15:0], sn[7:0]}
    int hold[256];           // extra stall cycles to spend at each i value

    typedef struct {
        int kind;        // 0 none, 1 fifty isolated stalls, 2 burst of 20, 3 burst of 3 at i=1
        int glitch_i;    // i value at which sn is shown +2 for one cycle (0 = none)
        int rdy_lat;     // cycles res_ready stays low after res_valid rises
        bit chain;       // present S on the transfer cycle
        bit abort;       // reset while REPORT instead of transferring
        int exp_stalls;
        bit exp_err;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, let the edge pass, then score the result
    task automatic tick(input logic [7:0] sn, input logic [7:0] i, input logic rdy);
        logic xfer, was_valid, rst_now;
        logic [24:0] e;
        int s;
        u_if.sn_in = sn;  u_if.i_in = i;  u_if.res_ready = rdy;
        u_if4.sn_in = sn; u_if4.i_in = i; u_if4.res_ready = rdy;
        was_valid = u_if.res_valid;
        xfer      = was_valid && rdy;
        rst_now   = rst;
        @(posedge clk);
        #1;
        if (xfer && !rst_now) begin
            n_xfer++;
            check("xfer_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (was_valid && !xfer && !rst_now) check("valid_hold", int'(u_if.res_valid), 1);
        if (u_if.res_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_valid: got res_valid=1 expected no record pending");
            end else begin
                e = exp_q[0];
                s = int'(e[23:8]);
                check("res_sn", int'(u_if.res_sn), int'(e[7:0]));
                check("res_stalls", int'(u_if.res_stalls), s);
                check("res_err", int'(u_if.res_err), int'(e[24]));
                check("res_valid_w4", int'(u_if4.res_valid), 1);
                check("res_stalls_w4", int'(u_if4.res_stalls), (s > 15) ? 15 : s);
                check("res_err_w4", int'(u_if4.res_err), int'(e[24]));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, int'(u_if.res_valid), 0);
        check({tag, "_sn"}, int'(u_if.res_sn), 0);
        check({tag, "_stalls"}, int'(u_if.res_stalls), 0);
        check({tag, "_err"}, int'(u_if.res_err), 0);
        check({tag, "_err_live"}, int'(u_if.err_live), 0);
        check({tag, "_busy"}, int'(u_if.busy), 0);
        check({tag, "_state"}, int'(u_if.state_dbg), 0);
        check({tag, "_stalls_w4"}, int'(u_if4.res_stalls), 0);
    endtask

    // Play one counter run from i=1 to LIMIT+1 using hold[] for the stall cycles
    task automatic run_counter(input int glitch_i, input int rdy_lat, input bit armed,
                               input bit chain, input bit abort,
                               input int exp_stalls, input bit exp_err);
        logic [7:0] sn;
        int sat;
        for (int i = 1; i <= LIMIT + 1; i++) begin
            if (i == LIMIT + 1) begin
                check("valid_early", int'(u_if.res_valid), 0);
                sat = (exp_stalls > 65535) ? 65535 : exp_stalls;
                exp_q.push_back({exp_err, 16'(sat), 8'(LIMIT)});
                // res_ready already high must not shorten the latency
                tick(8'(LIMIT), 8'(LIMIT + 1), 1'b1);
                check("valid_rise", int'(u_if.res_valid), 1);
                check("busy_report", int'(u_if.busy), 1);
            end else begin
                sn = 8'(i - 1);
                if (!(armed && i == 1)) begin
                    if (i == glitch_i) begin
                        tick(sn + 8'd2, 8'(i), 1'b0);
                        check("err_live_set", int'(u_if.err_live), 1);
                    end else begin
                        tick(sn, 8'(i), 1'b0);
                    end
                    if (i == 1) begin
                        check("busy_on_start", int'(u_if.busy), 1);
                        check("err_live_clear", int'(u_if.err_live), 0);
                    end
                end
                for (int h = 0; h < hold[i]; h++) tick(sn, 8'(i), 1'($urandom_range(0, 1)));
            end
        end
        for (int k = 0; k < rdy_lat; k++) tick(8'(LIMIT), 8'(LIMIT + 1), 1'b0);
        if (abort) begin
            rst = 1'b1;
            tick(8'(LIMIT), 8'(LIMIT + 1), 1'b0);
            rst = 1'b0;
            exp_q.delete();
            check_all_zero("abort");
        end else begin
            if (chain) tick(8'd0, 8'd1, 1'b1);
            else       tick(8'(LIMIT), 8'(LIMIT + 1), 1'b1);
            check("valid_fall", int'(u_if.res_valid), 0);
            check("busy_after", int'(u_if.busy), int'(chain));
        end
        for (int k = 0; k < 256; k++) hold[k] = 0;
    endtask

    initial begin
        vec_t vecs[10];
        bit armed;
        int xfer_before, sum, pct, glitch, lat, junk;
        bit chain;
        logic [7:0] ji, js;

        vecs[0] = '{0, 0,   0,  1'b0, 1'b0, 0,  1'b0};
        vecs[1] = '{1, 0,   3,  1'b0, 1'b0, 50, 1'b0};
        vecs[2] = '{0, 0,   10, 1'b0, 1'b0, 0,  1'b0};
        vecs[3] = '{0, 37,  1,  1'b0, 1'b0, 0,  1'b1};
        vecs[4] = '{0, 0,   0,  1'b0, 1'b0, 0,  1'b0};
        vecs[5] = '{2, 0,   2,  1'b0, 1'b0, 20, 1'b0};
        vecs[6] = '{0, 0,   4,  1'b0, 1'b1, 0,  1'b0};
        vecs[7] = '{3, 0,   0,  1'b1, 1'b0, 3,  1'b0};
        vecs[8] = '{0, 200, 0,  1'b0, 1'b0, 0,  1'b1};
        vecs[9] = '{0, 2,   1,  1'b0, 1'b0, 0,  1'b1};

        for (int k = 0; k < 256; k++) hold[k] = 0;

        // Reset with a start pattern on the inputs: it must not arm anything
        rst = 1'b1;
        tick(8'd0, 8'd1, 1'b1);
        tick(8'd0, 8'd1, 1'b1);
        check_all_zero("reset");
        rst = 1'b0;

        armed = 1'b0;
        for (int v = 0; v < 10; v++) begin
            case (vecs[v].kind)
                1: for (int k = 60; k < 160; k += 2) hold[k] = 1;
                2: hold[100] = 20;
                3: hold[1] = 3;
                default: ;
            endcase
            xfer_before = n_xfer;
            run_counter(vecs[v].glitch_i, vecs[v].rdy_lat, armed, vecs[v].chain,
                        vecs[v].abort, vecs[v].exp_stalls, vecs[v].exp_err);
            check($sformatf("xfer_count_v%0d", v), n_xfer - xfer_before,
                  vecs[v].abort ? 0 : 1);
            armed = vecs[v].chain;
        end

        // Random runs: random stall cycles, sn corruption, sink latency, junk cycles while halted
        for (int r = 0; r < 12; r++) begin
            if (!armed) begin
                junk = $urandom_range(0, 3);
                for (int j = 0; j < junk; j++) begin
                    ji = 8'($urandom_range(0, 255));
                    js = 8'($urandom_range(0, 255));
                    if (ji == 8'd1 && js == 8'd0) ji = 8'd2;
                    tick(js, ji, 1'($urandom_range(0, 1)));
                    check("halt_idle_valid", int'(u_if.res_valid), 0);
                    check("halt_idle_busy", int'(u_if.busy), 0);
                end
            end
            pct = $urandom_range(0, 30);
            sum = 0;
            for (int k = 1; k <= LIMIT; k++) begin
                hold[k] = ($urandom_range(0, 99) < pct) ? $urandom_range(1, 3) : 0;
                sum += hold[k];
            end
            glitch = ($urandom_range(0, 2) == 0) ? $urandom_range(2, LIMIT) : 0;
            lat    = $urandom_range(0, 6);
            chain  = 1'($urandom_range(0, 1));
            xfer_before = n_xfer;
            run_counter(glitch, lat, armed, chain, 1'b0, sum, glitch != 0);
            check("xfer_count_rand", n_xfer - xfer_before, 1);
            armed = chain;
        end

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
